// File: rtl/counter_cmd_ctrl.sv
// Button-level to counter-command sequencer with hold auto-repeat.
// Optional macro REPEAT_ACCEL_EN halves the repeat period after ACCEL_AFTER repeats.
module counter_cmd_ctrl #(
  parameter int WIDTH         = 8,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int SATURATE      = 1,
  parameter int ACCEL_AFTER   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_lvl,
  input  logic             dn_lvl,
  input  logic             clr_lvl,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_ce,
  output logic             cnt_up,
  output logic             cnt_clr,
  output logic             rpt_active
);

  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] RPT_LD  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT,
    S_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_nstate;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_ntimer;
  logic [TW-1:0]   w_rld;
  logic            r_dir;
  logic            w_ndir;
  logic            r_up_p;
  logic            r_dn_p;
  logic            r_clr_p;
  logic            r_ce;
  logic            r_up;
  logic            r_clr;
  logic            r_rpt;
  logic            w_up_r;
  logic            w_dn_r;
  logic            w_clr_r;
  logic            w_act;
  logic            w_opp;
  logic            w_step;
  logic            w_clr;
  logic            w_sat;
  logic            w_ce;

  assign w_up_r  = up_lvl & ~r_up_p;
  assign w_dn_r  = dn_lvl & ~r_dn_p;
  assign w_clr_r = clr_lvl & ~r_clr_p;
  assign w_act   = r_dir ? up_lvl : dn_lvl;
  assign w_opp   = r_dir ? dn_lvl : up_lvl;

`ifdef REPEAT_ACCEL_EN
  localparam int FASTP = (REPEAT_CYCLES / 2 < 1) ? 1 : REPEAT_CYCLES / 2;
  localparam logic [TW-1:0] FAST_LD = TW'(FASTP - 1);
  localparam int CW = (ACCEL_AFTER > 0) ? $clog2(ACCEL_AFTER + 1) : 1;
  localparam logic [CW-1:0] ACC_MAX = CW'(ACCEL_AFTER);

  logic [CW-1:0] r_rcnt;

  assign w_rld = (r_rcnt >= ACC_MAX) ? FAST_LD : RPT_LD;

  // Count repeat steps in the current hold, saturating, cleared outside REPEAT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcnt <= '0;
    end else if (w_nstate != S_REPEAT) begin
      r_rcnt <= '0;
    end else if (w_step && (r_rcnt != ACC_MAX)) begin
      r_rcnt <= r_rcnt + 1'b1;
    end
  end
`else
  assign w_rld = RPT_LD;
`endif

  // Next state, timer and command decisions; clear rise overrides everything
  always_comb begin
    w_nstate = r_state;
    w_ntimer = r_timer;
    w_ndir   = r_dir;
    w_step   = 1'b0;
    w_clr    = 1'b0;
    if (w_clr_r) begin
      w_clr    = 1'b1;
      w_nstate = S_WAIT;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_up_r && !dn_lvl) begin
            w_step   = 1'b1;
            w_ndir   = 1'b1;
            w_ntimer = HOLD_LD;
            w_nstate = S_HOLD;
          end else if (w_dn_r && !up_lvl) begin
            w_step   = 1'b1;
            w_ndir   = 1'b0;
            w_ntimer = HOLD_LD;
            w_nstate = S_HOLD;
          end else if (w_up_r || w_dn_r) begin
            w_nstate = S_WAIT;
          end
        end
        S_HOLD, S_REPEAT: begin
          if (!w_act) begin
            w_nstate = S_IDLE;
          end else if (w_opp) begin
            w_nstate = S_WAIT;
          end else if (r_timer == '0) begin
            w_step   = 1'b1;
            w_ntimer = w_rld;
            w_nstate = S_REPEAT;
          end else begin
            w_ntimer = r_timer - 1'b1;
          end
        end
        S_WAIT: begin
          if (!up_lvl && !dn_lvl && !clr_lvl) begin
            w_nstate = S_IDLE;
          end
        end
        default: w_nstate = S_WAIT;
      endcase
    end
  end

  assign w_sat = (SATURATE != 0) &&
                 (w_ndir ? (&count) : (count == '0));
  assign w_ce  = w_step & ~w_sat;

  // State, timer, direction and edge-detect history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_timer <= '0;
      r_dir   <= 1'b0;
      r_up_p  <= 1'b1;
      r_dn_p  <= 1'b1;
      r_clr_p <= 1'b1;
    end else begin
      r_state <= w_nstate;
      r_timer <= w_ntimer;
      r_dir   <= w_ndir;
      r_up_p  <= up_lvl;
      r_dn_p  <= dn_lvl;
      r_clr_p <= clr_lvl;
    end
  end

  // Registered command outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ce  <= 1'b0;
      r_up  <= 1'b0;
      r_clr <= 1'b0;
      r_rpt <= 1'b0;
    end else begin
      r_ce  <= w_ce;
      r_up  <= w_ce & w_ndir;
      r_clr <= w_clr;
      r_rpt <= (w_nstate == S_REPEAT);
    end
  end

  assign cnt_ce     = r_ce;
  assign cnt_up     = r_up;
  assign cnt_clr    = r_clr;
  assign rpt_active = r_rpt;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Self-checking bench for counter_cmd_ctrl, saturating and wrapping builds.
// Reference model schedules steps by absolute edge deadlines.
module tb_counter_cmd_ctrl;

  localparam int HOLD = 10;
  localparam int RPT  = 4;
  localparam int ACC  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_lvl;
  logic       dn_lvl;
  logic       clr_lvl;
  logic [7:0] count;
  logic       ce_s, up_s, clr_s, rpt_s;
  logic       ce_w, up_w, clr_w, rpt_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_cmd_ctrl #(
    .WIDTH(8), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT),
    .SATURATE(1), .ACCEL_AFTER(ACC)
  ) u_sat (
    .clk(clk), .rst(rst), .up_lvl(up_lvl), .dn_lvl(dn_lvl),
    .clr_lvl(clr_lvl), .count(count), .cnt_ce(ce_s), .cnt_up(up_s),
    .cnt_clr(clr_s), .rpt_active(rpt_s)
  );

  counter_cmd_ctrl #(
    .WIDTH(8), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT),
    .SATURATE(0), .ACCEL_AFTER(ACC)
  ) u_wrap (
    .clk(clk), .rst(rst), .up_lvl(up_lvl), .dn_lvl(dn_lvl),
    .clr_lvl(clr_lvl), .count(count), .cnt_ce(ce_w), .cnt_up(up_w),
    .cnt_clr(clr_w), .rpt_active(rpt_w)
  );

  localparam int M_IDLE = 0;
  localparam int M_HELD = 1;
  localparam int M_WAIT = 2;

  int cyc;
  int m_mode;
  bit m_dir;
  int m_next;
  int m_nrep;
  bit pu, pd, pc;
  bit e_ce_s, e_ce_w, e_up, e_clr, e_rpt;

  function automatic int period(int nrep);
`ifdef REPEAT_ACCEL_EN
    if (nrep >= ACC) return (RPT / 2 < 1) ? 1 : RPT / 2;
`endif
    return RPT;
  endfunction

  task model_reset();
    pu = 1; pd = 1; pc = 1;
    m_mode = M_WAIT; m_dir = 0; m_nrep = 0; m_next = 0;
    e_ce_s = 0; e_ce_w = 0; e_up = 0; e_clr = 0; e_rpt = 0;
  endtask

  task model_edge();
    bit ur, dr, cr, stp, sat;
    ur = up_lvl && !pu;
    dr = dn_lvl && !pd;
    cr = clr_lvl && !pc;
    stp = 0;
    e_clr = 0;
    if (cr) begin
      e_clr = 1;
      m_mode = M_WAIT;
    end else if (m_mode == M_IDLE) begin
      if (ur && !dn_lvl) begin
        stp = 1; m_dir = 1; m_next = cyc + HOLD;
        m_nrep = 0; m_mode = M_HELD;
      end else if (dr && !up_lvl) begin
        stp = 1; m_dir = 0; m_next = cyc + HOLD;
        m_nrep = 0; m_mode = M_HELD;
      end else if (ur || dr) begin
        m_mode = M_WAIT;
      end
    end else if (m_mode == M_HELD) begin
      if (!(m_dir ? up_lvl : dn_lvl)) m_mode = M_IDLE;
      else if (m_dir ? dn_lvl : up_lvl) m_mode = M_WAIT;
      else if (cyc == m_next) begin
        stp = 1;
        m_next = cyc + period(m_nrep);
        m_nrep++;
      end
    end else begin
      if (!up_lvl && !dn_lvl && !clr_lvl) m_mode = M_IDLE;
    end
    if (m_mode != M_HELD) m_nrep = 0;
    sat = m_dir ? (count == 8'hFF) : (count == 8'h00);
    e_ce_w = stp;
    e_ce_s = stp && !sat;
    e_up = m_dir;
    e_rpt = (m_mode == M_HELD) && (m_nrep > 0);
    pu = up_lvl; pd = dn_lvl; pc = clr_lvl;
    cyc++;
  endtask

  task chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d observed=%b expected=%b",
             tag, cyc, obs, exp);
    end
  endtask

  task check_all();
    chk("ce_sat", ce_s, e_ce_s);
    chk("clr_sat", clr_s, e_clr);
    chk("rpt_sat", rpt_s, e_rpt);
    if (e_ce_s) chk("up_sat", up_s, e_up);
    chk("ce_wrap", ce_w, e_ce_w);
    chk("clr_wrap", clr_w, e_clr);
    chk("rpt_wrap", rpt_w, e_rpt);
    if (e_ce_w) chk("up_wrap", up_w, e_up);
  endtask

  task check_zero(input string tag);
    chk({tag, "_ce_s"}, ce_s, 1'b0);
    chk({tag, "_up_s"}, up_s, 1'b0);
    chk({tag, "_clr_s"}, clr_s, 1'b0);
    chk({tag, "_rpt_s"}, rpt_s, 1'b0);
    chk({tag, "_ce_w"}, ce_w, 1'b0);
    chk({tag, "_rpt_w"}, rpt_w, 1'b0);
  endtask

  task tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1; up_lvl = 0; dn_lvl = 0; clr_lvl = 0; count = 8'd5;
    cyc = 0;
    model_reset();
    #12;
    check_zero("reset");
    rst = 0;
    run(2);

    up_lvl = 1; run(31); up_lvl = 0; run(3);

    dn_lvl = 1; run(3); dn_lvl = 0; run(3);

    up_lvl = 1; run(14); clr_lvl = 1; run(3);
    clr_lvl = 0; run(4); up_lvl = 0; run(2);
    up_lvl = 1; run(5); up_lvl = 0; run(2);

    up_lvl = 1; dn_lvl = 1; run(3);
    up_lvl = 0; run(3); dn_lvl = 0; run(2);
    up_lvl = 1; run(5); dn_lvl = 1; run(15);
    up_lvl = 0; dn_lvl = 0; run(2);

    count = 8'hFF; up_lvl = 1; run(25); up_lvl = 0; run(2);
    count = 8'h00; dn_lvl = 1; run(25); dn_lvl = 0; run(2);

    count = 8'd5; up_lvl = 1; run(30); up_lvl = 0; run(2);

    up_lvl = 1; run(16);
    #3 rst = 1;
    #1 check_zero("async_rst");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check_zero("in_rst");
    end
    #3 rst = 0;
    model_reset();
    run(20); up_lvl = 0; run(3);
    dn_lvl = 1; run(4); dn_lvl = 0; run(2);

    for (int s = 0; s < 300; s++) begin
      int r;
      r = int'($urandom_range(0, 9));
      up_lvl  = (r < 4) || (r == 8);
      dn_lvl  = (r >= 4 && r < 7) || (r == 8);
      clr_lvl = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: count = 8'h00;
        1: count = 8'hFF;
        default: count = 8'($urandom);
      endcase
      run(int'($urandom_range(1, 25)));
    end

    up_lvl = 0; dn_lvl = 0; clr_lvl = 0;
    run(3);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_cmd_ctrl.md
Name: counter_cmd_ctrl

Overview:
- Command sequencer between the debounced button levels and an 8-bit up/down counter (ce/dir/clr style).
- Converts three debounced levels into single-cycle counter commands: up, down and clear.
- Adds hold-to-auto-repeat, up/down conflict lockout, clear priority and optional saturation at the counter limits.
- Sits after the per-button debounce stage; its outputs drive the counter's enable, direction and clear inputs directly.

Parameters:
- WIDTH, 8, width of the count input.
- HOLD_CYCLES, 50000000, clocks from the initial step to the first repeat step (500 ms at 100 MHz); must be >= 2.
- REPEAT_CYCLES, 10000000, clocks between repeat steps (100 ms); must be >= 2.
- SATURATE, 1, 1 = suppress steps past all-ones or zero; 0 = steps always issued (counter wraps).
- ACCEL_AFTER, 8, repeat steps before acceleration; used only with REPEAT_ACCEL_EN.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- up_lvl  in  1  debounced "up" button level.
- dn_lvl  in  1  debounced "down" button level.
- clr_lvl  in  1  debounced "clear" button level.
- count  in  WIDTH  current counter value, used for saturation.
- cnt_ce  out  1  one-cycle step enable to the counter.
- cnt_up  out  1  step direction (1 = up), valid while cnt_ce = 1.
- cnt_clr  out  1  one-cycle synchronous clear to the counter.
- rpt_active  out  1  high while in the REPEAT state.

Behaviour:
- Interface: single clock clk; rst is asynchronous and active-high.
- Reset values: all outputs 0, timer 0, repeat count 0, state WAIT_REL. Buttons held through reset are ignored until released.
- Edge detect: registered previous copies of up_lvl, dn_lvl and clr_lvl, reset to 1. rise = lvl & ~prev.
- All outputs are registered. A rising input sampled at edge n produces its response in the cycle after edge n (latency 1).
- Clear priority: a clr rise in any state pulses cnt_clr for 1 cycle, forces cnt_ce = 0 that cycle and moves to WAIT_REL. Clear never repeats.
- States:
  - IDLE: up rise with dn_lvl = 0 → step up, timer = HOLD_CYCLES-1, dir = up, go to HOLD. dn rise with up_lvl = 0 → same with dir = down. Both rise in the same cycle, or one rises while the other is already high → no step, go to WAIT_REL.
  - HOLD: active button low → IDLE, no step. Opposite button high → WAIT_REL, no step. Timer = 0 → step in dir, timer = REPEAT_CYCLES-1, go to REPEAT. Otherwise timer decrements.
  - REPEAT: same release and conflict rules as HOLD. Timer = 0 → step, reload REPEAT_CYCLES-1.
  - WAIT_REL: stay until up_lvl = dn_lvl = clr_lvl = 0, then go to IDLE.
- Timing: initial step at cycle t. Repeats at t+HOLD_CYCLES, then every REPEAT_CYCLES thereafter.
- Step = cnt_ce high for 1 cycle with cnt_up = dir.
- Saturation (SATURATE = 1): an up step at count = all-ones, or a down step at count = 0, is suppressed (cnt_ce stays 0). The state and timer advance exactly as if the step had been issued. The count input is sampled in the same cycle the step decision is made.
- Release and repeat-expiry in the same cycle: release wins, no step.
- Timer width: $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).
- Repeat counter width: $clog2(ACCEL_AFTER+1); it saturates at ACCEL_AFTER and clears on leaving REPEAT.
- Async reset mid-repeat: outputs drop to 0 immediately and the state goes to WAIT_REL.

Optional Feature:
- REPEAT_ACCEL_EN defined: after ACCEL_AFTER repeat steps in one hold, the reload value becomes (REPEAT_CYCLES/2)-1, with a period floor of 1. The repeat counter resets on leaving REPEAT.
- REPEAT_ACCEL_EN undefined: the repeat period is always REPEAT_CYCLES. No repeat counter is synthesised and ACCEL_AFTER is ignored.

Test Plan:
- HOLD_CYCLES=10, REPEAT_CYCLES=4, count=5. Raise up_lvl at edge 0 and hold 30 cycles → cnt_ce/cnt_up=1 at cycles 1, 11, 15, 19, 23, 27, 31; rpt_active=1 from cycle 11 until after release.
- Press dn_lvl for 3 cycles → exactly one cnt_ce with cnt_up=0; state returns to IDLE; no repeat.
- Hold up_lvl into REPEAT, then raise clr_lvl → one cnt_clr pulse, no cnt_ce that cycle, no further steps until all buttons are released, then normal response to a new press.
- Raise up_lvl and dn_lvl on the same edge → no cnt_ce; state stays WAIT_REL until both are low. Also: raise dn_lvl while in HOLD → repeats stop.
- SATURATE=1, count=8'hFF, hold up_lvl → cnt_ce never asserts and timer cycling continues. Same test with count=0 and dn_lvl → no steps. With SATURATE=0 → steps issued.
- REPEAT_ACCEL_EN defined, ACCEL_AFTER=2, REPEAT_CYCLES=4 → repeat intervals 4, 4, then 2 thereafter. Assert rst mid-sequence → outputs 0 immediately, and a button held through reset produces no step.
